// File: rtl/rom_stream_loader_if.sv
// Bus bundle for rom_stream_loader: request, byte source and ioctl-style sink.
// master = loader side, slave = requester/source/core side.
interface rom_stream_loader_if;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned CKW = 16;

    logic           start;
    logic [IW-1:0]  index;
    logic [AW-1:0]  length;
    logic           src_valid;
    logic [DW-1:0]  src_data;
    logic           src_ready;
    logic           ioctl_wait;
    logic           ioctl_download;
    logic           ioctl_wr;
    logic [AW-1:0]  ioctl_addr;
    logic [DW-1:0]  ioctl_dout;
    logic [IW-1:0]  ioctl_index;
    logic           busy;
    logic           done;
    logic [CKW-1:0] checksum;

    modport master (
        input  start, index, length, src_valid, src_data, ioctl_wait,
        output src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
               ioctl_index, busy, done, checksum
    );

    modport slave (
        output start, index, length, src_valid, src_data, ioctl_wait,
        input  src_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
               ioctl_index, busy, done, checksum
    );
endinterface

// File: rtl/rom_stream_loader.sv
// rom_stream_loader: streams a byte source into an ioctl-style download window.
// Optional feature macro: LOADER_CHECKSUM_EN (running 16-bit byte sum on checksum).
// src_ready is combinational (state + ioctl_wait) so a stall blocks the handshake
// in the same cycle; every other output is a flop.
module rom_stream_loader #(
    parameter int unsigned WR_GAP      = 3,
    parameter int unsigned TAIL_CYCLES = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_stream_loader_if.master  bus
);
    localparam int unsigned AW  = 25;
    localparam int unsigned DW  = 8;
    localparam int unsigned IW  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned CKW = 16;

    // The FETCH cycle is the last of the WR_GAP idle cycles, so GAP itself lasts WR_GAP-1.
    localparam int unsigned GAP_CYCLES = (WR_GAP > 1) ? WR_GAP - 1 : 0;
    localparam bit          SKIP_GAP   = (GAP_CYCLES == 0);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TAIL_LOAD = CW'(TAIL_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;

    logic [2:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] length_q,   length_d;
    logic [DW-1:0] dout_q,     dout_d;
    logic [IW-1:0] index_q,    index_d;
    logic          download_q, download_d;
    logic          wr_q,       wr_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          src_ready_c;
    logic          last_c;
    logic          wr_done_c;

    assign last_c    = (addr_q == length_q - AW'(1));
    assign wr_done_c = (state_q == S_WRITE && SKIP_GAP) || (state_q == S_GAP && cnt_q == '0);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        length_d    = length_q;
        dout_d      = dout_q;
        index_d     = index_q;
        src_ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.length != '0) begin
                    index_d  = bus.index;
                    length_d = bus.length;
                    addr_d   = '0;
                    state_d  = S_ARM;
                end
            end
            S_ARM:   state_d = S_FETCH;
            S_FETCH: begin
                src_ready_c = !bus.ioctl_wait;
                if (bus.src_valid && src_ready_c) begin
                    dout_d  = bus.src_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!SKIP_GAP) begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_TAIL: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // End of a write slot: advance the address, then next byte or tail.
        if (wr_done_c) begin
            addr_d = addr_q + AW'(1);
            if (last_c) begin
                cnt_d   = TAIL_LOAD;
                state_d = S_TAIL;
            end else begin
                state_d = S_FETCH;
            end
        end

        download_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        wr_d       = (state_d == S_WRITE);
        done_d     = (state_q == S_TAIL) && (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            length_q   <= '0;
            dout_q     <= '0;
            index_q    <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            length_q   <= length_d;
            dout_q     <= dout_d;
            index_q    <= index_d;
            download_q <= download_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [CKW-1:0] checksum_q, checksum_d;

    // Clear on accepted start, accumulate the byte being written.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && state_d == S_ARM) checksum_d = '0;
        else if (state_q == S_WRITE)               checksum_d = checksum_q + CKW'(dout_q);
    end

    // Checksum register.
    always_ff @(posedge clk_sys) begin
        if (reset) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = CKW'(0);
`endif

    assign bus.src_ready      = src_ready_c;
    assign bus.ioctl_download = download_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign bus.ioctl_index    = index_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_rom_stream_loader.sv
// Testbench for rom_stream_loader (WR_GAP=3, TAIL_CYCLES=16): vector table of
// downloads plus hand-written zero-length and mid-download reset sequences.
module tb_rom_stream_loader;
    typedef struct {
        int         len;
        logic [7:0] idx;
        int         stall;    // ioctl_wait cycles raised after the first write
        bit         tog;      // src_valid toggles every other cycle
        bit         restart;  // re-issue start with other index/length while busy
        int         window;   // expected download-high cycles, 0 = not checked
    } vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rom_stream_loader_if bus ();

    rom_stream_loader #(.WR_GAP(3), .TAIL_CYCLES(16)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    wr_t        exp_q[$];
    logic [7:0] src_q[$];
    bit         src_toggle = 1'b0;
    bit         tog        = 1'b0;
    logic [7:0] cur_idx    = 8'h00;

    int nwr, ndone, win, first_wr_cyc, last_wr_cyc, min_sp, max_sp;
    bit prev_dl = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        vec_cnt++;
        if (act < min) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    task automatic flag(input string name);
        err_cnt++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte source: present head of src_q, pop on handshake.
    always @(negedge clk) begin
        tog = ~tog;
        bus.src_valid = (src_q.size() > 0) && (!src_toggle || tog);
        bus.src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        #1;
        if (bus.src_ready && (!bus.ioctl_download || bus.ioctl_wr)) flag("src_ready_outside_fetch");
        if (bus.src_valid && bus.src_ready) void'(src_q.pop_front());
    end

    // Output monitor and scoreboard.
    always @(posedge clk) begin
        #1;
        if (bus.ioctl_download) begin
            win++;
            if (bus.ioctl_index !== cur_idx) flag("index_changed_while_busy");
        end
        if (bus.ioctl_wr) begin
            if (!bus.ioctl_download) flag("wr_outside_download");
            if (nwr == 0) begin
                first_wr_cyc = cyc;
            end else begin
                if (cyc - last_wr_cyc < min_sp) min_sp = cyc - last_wr_cyc;
                if (cyc - last_wr_cyc > max_sp) max_sp = cyc - last_wr_cyc;
            end
            last_wr_cyc = cyc;
            nwr++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h, expected no write", bus.ioctl_addr, bus.ioctl_dout);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.ioctl_addr), 32'(e.addr));
                check("wr_data", 32'(bus.ioctl_dout), 32'(e.data));
            end
        end
        if (bus.done) begin
            ndone++;
            if (!(prev_dl && !bus.ioctl_download)) flag("done_not_at_download_fall");
        end
        prev_dl = bus.ioctl_download;
    end

    task automatic clear_run();
        nwr = 0; ndone = 0; win = 0; first_wr_cyc = 0; last_wr_cyc = 0;
        min_sp = 1000000; max_sp = 0;
    endtask

    task automatic load_bytes(input int len, input bit fixed, output logic [15:0] sum);
        logic [7:0] b;
        sum = 16'h0;
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom_range(0, 255));
            src_q.push_back(b);
            exp_q.push_back('{addr: 25'(i), data: b});
            sum = sum + 16'(b);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit fixed);
        int start_cyc;
        logic [15:0] sum;
        clear_run();
        src_toggle = v.tog;
        load_bytes(v.len, fixed, sum);
        @(negedge clk);
        cur_idx    = v.idx;
        bus.start  = 1'b1;
        bus.index  = v.idx;
        bus.length = 25'(v.len);
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        if (v.restart) begin
            bus.start  = 1'b1;
            bus.index  = ~v.idx;
            bus.length = 25'(7);
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (v.stall > 0) begin
            for (int i = 0; i < 200 && nwr < 1; i++) @(negedge clk);
            bus.ioctl_wait = 1'b1;
            repeat (v.stall) @(negedge clk);
            bus.ioctl_wait = 1'b0;
        end
        for (int i = 0; i < 3000 && ndone < 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_count", 32'(ndone), 32'd1);
        check("wr_count", 32'(nwr), 32'(v.len));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("source_drained", 32'(src_q.size()), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("checksum", 32'(bus.checksum), 32'(sum));
`else
        check("checksum", 32'(bus.checksum), 32'd0);
`endif
        if (!v.tog) begin
            // ARM, FETCH, then the write cycle
            check("first_wr_latency", 32'(first_wr_cyc - start_cyc), 32'd2);
        end
        if (v.stall > 0) check_ge("stalled_wr_spacing", max_sp, v.stall);
        if (!v.tog && v.stall == 0 && v.len > 1) begin
            check("wr_spacing_min", 32'(min_sp), 32'd4);
            check("wr_spacing_max", 32'(max_sp), 32'd4);
        end
        if (v.window != 0) check("download_window", 32'(win), 32'(v.window));
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        vec_t vecs[5];
        int   any_busy, any_dl, any_wr, done_before;
        logic [15:0] dummy;

        // window = ARM + 4 cycles per byte + 16 tail cycles
        vecs[0] = '{len: 4, idx: 8'h00, stall: 0,  tog: 1'b0, restart: 1'b0, window: 33};
        vecs[1] = '{len: 3, idx: 8'h5A, stall: 10, tog: 1'b0, restart: 1'b0, window: 0};
        vecs[2] = '{len: 8, idx: 8'hA5, stall: 0,  tog: 1'b1, restart: 1'b0, window: 0};
        vecs[3] = '{len: 1, idx: 8'hFF, stall: 0,  tog: 1'b0, restart: 1'b0, window: 21};
        vecs[4] = '{len: 2, idx: 8'h3C, stall: 0,  tog: 1'b0, restart: 1'b1, window: 25};

        bus.start = 1'b0; bus.index = 8'h00; bus.length = '0;
        bus.src_valid = 1'b0; bus.src_data = 8'h00; bus.ioctl_wait = 1'b0;
        clear_run();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_download", 32'(bus.ioctl_download), 32'd0);
        check("rst_wr",       32'(bus.ioctl_wr),       32'd0);
        check("rst_busy",     32'(bus.busy),           32'd0);
        check("rst_done",     32'(bus.done),           32'd0);
        check("rst_src_ready",32'(bus.src_ready),      32'd0);
        check("rst_addr",     32'(bus.ioctl_addr),     32'd0);
        check("rst_dout",     32'(bus.ioctl_dout),     32'd0);
        check("rst_index",    32'(bus.ioctl_index),    32'd0);
        check("rst_checksum", 32'(bus.checksum),       32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i == 0);

        // Zero-length start must be ignored.
        any_busy = 0; any_dl = 0; any_wr = 0;
        bus.start = 1'b1; bus.index = 8'h77; bus.length = '0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_busy |= int'(bus.busy);
            any_dl   |= int'(bus.ioctl_download);
            any_wr   |= int'(bus.ioctl_wr);
        end
        check("len0_busy",     32'(any_busy), 32'd0);
        check("len0_download", 32'(any_dl),   32'd0);
        check("len0_wr",       32'(any_wr),   32'd0);

        // Reset in GAP after the addr-2 write of a 16-byte download.
        clear_run();
        src_toggle = 1'b0;
        load_bytes(16, 1'b0, dummy);
        cur_idx = 8'h42;
        bus.start = 1'b1; bus.index = 8'h42; bus.length = 25'd16;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 200 && nwr < 3; i++) @(negedge clk);
        check("pre_reset_writes", 32'(nwr), 32'd3);
        @(negedge clk);
        done_before = ndone;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rst_download", 32'(bus.ioctl_download), 32'd0);
        check("mid_rst_wr",       32'(bus.ioctl_wr),       32'd0);
        check("mid_rst_busy",     32'(bus.busy),           32'd0);
        check("mid_rst_src_ready",32'(bus.src_ready),      32'd0);
        check("mid_rst_addr",     32'(bus.ioctl_addr),     32'd0);
        check("mid_rst_dout",     32'(bus.ioctl_dout),     32'd0);
        check("mid_rst_index",    32'(bus.ioctl_index),    32'd0);
        check("mid_rst_checksum", 32'(bus.checksum),       32'd0);
        exp_q.delete();
        src_q.delete();
        cur_idx = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", 32'(ndone - done_before), 32'd0);

        // Fresh download after the abort restarts at address 0.
        run_vec('{len: 2, idx: 8'h99, stall: 0, tog: 1'b0, restart: 1'b0, window: 25}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
